// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronised rising edges of sig_in over GATE_CYCLES clk cycles,
// saturating at MAX_COUNT, and publishes each completed window on count_out with a count_valid pulse.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int MAX_COUNT   = 9999,
  parameter int COUNT_W     = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sig_in,
  input  logic               enable,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  output logic               overflow,
  output logic               gate_active
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] MAX_CNT   = COUNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GATE = 2'd2
  } state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 prev_q;
  logic                 edge_det;
  logic [GATE_W-1:0]    gate_cnt;
  logic [COUNT_W-1:0]   edge_cnt;
  logic [COUNT_W-1:0]   edge_nxt;
  logic                 ovf_acc;
  logic                 ovf_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Saturating accumulate: once the count reaches MAX_COUNT further edges only latch the overflow flag.
  always_comb begin
    edge_nxt = edge_cnt;
    ovf_nxt  = ovf_acc;
    if (edge_det) begin
      if (edge_cnt == MAX_CNT) begin
        ovf_nxt = 1'b1;
      end else begin
        edge_nxt = edge_cnt + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      ovf_acc     <= 1'b0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      gate_active <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt    <= '0;
          edge_cnt    <= '0;
          ovf_acc     <= 1'b0;
          gate_active <= 1'b0;
          if (enable) begin
            state <= ARM;
          end
        end
        ARM: begin
          gate_cnt    <= '0;
          edge_cnt    <= '0;
          ovf_acc     <= 1'b0;
          gate_active <= enable;
          state       <= enable ? GATE : IDLE;
        end
        GATE: begin
          gate_active <= enable;
          if (gate_cnt == GATE_LAST) begin
            // The terminal cycle always completes, even when enable has just dropped.
            count_out   <= edge_nxt;
            overflow    <= ovf_nxt;
            count_valid <= 1'b1;
            gate_cnt    <= '0;
            edge_cnt    <= '0;
            ovf_acc     <= 1'b0;
            state       <= enable ? GATE : IDLE;
          end else if (!enable) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
            state    <= IDLE;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= edge_nxt;
            ovf_acc  <= ovf_nxt;
          end
        end
        default: begin
          state       <= IDLE;
          gate_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter with GATE_CYCLES=100: a nominal instance (MAX_COUNT=9999)
// and a saturating instance (MAX_COUNT=25) sharing clock, reset and sig_in.
module tb_freq_gate_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sig_in;
  logic        enable;
  logic        en_sat;
  logic [19:0] count_out;
  logic        count_valid;
  logic        overflow;
  logic        gate_active;
  logic [19:0] cnt_sat;
  logic        vld_sat;
  logic        ovf_sat;
  logic        act_sat;

  int evals = 0;
  int fails = 0;
  int ph    = 0;
  int mode  = 0;  // 0: sig_in driven by hand, 1: period-10 square wave, 2: toggle every clk

  always #5 clk = ~clk;

  freq_gate_counter #(
    .GATE_CYCLES(100), .MAX_COUNT(9999), .COUNT_W(20), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .enable(enable),
    .count_out(count_out), .count_valid(count_valid),
    .overflow(overflow), .gate_active(gate_active)
  );

  freq_gate_counter #(
    .GATE_CYCLES(100), .MAX_COUNT(25), .COUNT_W(20), .SYNC_STAGES(2)
  ) dut_sat (
    .clk(clk), .reset(reset), .sig_in(sig_in), .enable(en_sat),
    .count_out(cnt_sat), .count_valid(vld_sat),
    .overflow(ovf_sat), .gate_active(act_sat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    ph++;
    if (mode == 1) sig_in = ((ph % 10) < 5);
    else if (mode == 2) sig_in = ((ph % 2) == 1);
  endtask

  task automatic wait_valid(input bit sat, input int max_cyc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (((sat ? vld_sat : count_valid) !== 1'b1) && (n < max_cyc));
  endtask

  initial begin
    int n;
    int pulses;
    reset  = 1'b1;
    sig_in = 1'b0;
    enable = 1'b0;
    en_sat = 1'b0;

    // Reset held three cycles
    repeat (3) step();
    chk("rst_count_out", 32'(count_out), 0);
    chk("rst_count_valid", 32'(count_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_gate_active", 32'(gate_active), 0);
    reset = 1'b0;
    repeat (5) step();
    chk("idle_gate_active", 32'(gate_active), 0);
    chk("idle_count_valid", 32'(count_valid), 0);

    // Nominal square wave, period 10
    mode = 1;
    repeat (20) step();
    enable = 1'b1;
    step();
    chk("arm_gate_active", 32'(gate_active), 0);
    step();
    chk("gate_gate_active", 32'(gate_active), 1);
    wait_valid(0, 300, n);
    chk("first_pulse_latency", n + 2, 102);
    chk("sq_count_1", 32'(count_out), 10);
    chk("sq_overflow_1", 32'(overflow), 0);
    step();
    chk("valid_one_cycle", 32'(count_valid), 0);
    wait_valid(0, 300, n);
    chk("window_period", n + 1, 100);
    chk("sq_count_2", 32'(count_out), 10);

    // Drop enable mid-window: partial window discarded
    repeat (50) step();
    enable = 1'b0;
    step();
    chk("abort_gate_active", 32'(gate_active), 0);
    pulses = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (count_valid) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    chk("abort_count_held", 32'(count_out), 10);
    enable = 1'b1;
    wait_valid(0, 300, n);
    chk("rearm_latency", n, 102);
    chk("rearm_count", 32'(count_out), 10);

    // Reset in the middle of a window
    repeat (60) step();
    reset = 1'b1;
    step();
    chk("midrst_count_out", 32'(count_out), 0);
    chk("midrst_count_valid", 32'(count_valid), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    chk("midrst_gate_active", 32'(gate_active), 0);
    reset = 1'b0;
    wait_valid(0, 300, n);
    chk("postrst_latency", n, 102);
    wait_valid(0, 300, n);
    chk("postrst_period", n, 100);
    chk("postrst_count", 32'(count_out), 10);

    // Single pulse landing on the terminal cycle, then idle-low and held-high windows
    mode   = 0;
    sig_in = 1'b0;
    wait_valid(0, 300, n);
    wait_valid(0, 300, n);
    chk("low_window_count", 32'(count_out), 0);
    repeat (97) step();
    sig_in = 1'b1;
    step();
    step();
    sig_in = 1'b0;
    wait_valid(0, 300, n);
    chk("terminal_edge_timing", n, 1);
    chk("terminal_edge_count", 32'(count_out), 1);
    chk("terminal_edge_ovf", 32'(overflow), 0);
    wait_valid(0, 300, n);
    chk("after_terminal_count", 32'(count_out), 0);
    sig_in = 1'b1;
    wait_valid(0, 300, n);
    chk("rise_window_count", 32'(count_out), 1);
    wait_valid(0, 300, n);
    chk("high_window_count", 32'(count_out), 0);
    enable = 1'b0;

    // Saturation with MAX_COUNT=25
    mode   = 2;
    en_sat = 1'b1;
    wait_valid(1, 300, n);
    chk("sat_latency", n, 102);
    chk("sat_count_1", 32'(cnt_sat), 25);
    chk("sat_overflow_1", 32'(ovf_sat), 1);
    wait_valid(1, 300, n);
    chk("sat_count_2", 32'(cnt_sat), 25);
    chk("sat_overflow_2", 32'(ovf_sat), 1);
    mode = 1;
    wait_valid(1, 300, n);
    wait_valid(1, 300, n);
    chk("unsat_count", 32'(cnt_sat), 10);
    chk("unsat_overflow", 32'(ovf_sat), 0);
    chk("main_idle_held", 32'(count_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
